// File: rtl/fpu_mul_sched.sv
// Round-robin issue scheduler that shares one LAT-deep multiplier between requesters A and B.
// A tag pipeline steers each result back to its owner; the rounding mode is held while ops are in flight.
`timescale 1ns/1ps
module fpu_mul_sched #(
  parameter int LAT = 4,
  parameter int RMW = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           a_req_valid,
  output logic           a_req_ready,
  input  logic [63:0]    a_val_rm,
  input  logic [63:0]    a_val_rn,
  input  logic [RMW-1:0] a_rmode,
  input  logic           b_req_valid,
  output logic           b_req_ready,
  input  logic [63:0]    b_val_rm,
  input  logic [63:0]    b_val_rn,
  input  logic [RMW-1:0] b_rmode,
  output logic [63:0]    mul_val_rm,
  output logic [63:0]    mul_val_rn,
  output logic [RMW-1:0] mul_rmode,
  input  logic [63:0]    mul_val_ro,
  input  logic [1:0]     mul_ex_ok,
  output logic           res_a_valid,
  output logic           res_b_valid,
  output logic [63:0]    res_value,
  output logic           res_inexact,
  output logic           busy,
  output logic [2:0]     inflight
);
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic           last_grant_q, last_grant_d;
  logic [RMW-1:0] cur_rmode_q, cur_rmode_d;
  logic [2:0]     inflight_q, inflight_d;

  logic           winner;
  logic           any_valid;
  logic           eligible;
  logic           issue;
  logic           retire;
  logic [RMW-1:0] win_rmode;
  logic           unused_ex;

  // Arbitration: the non-winner is never substituted, so a blocked winner drains the pipe
  assign retire    = tag_v_q[LAT-1];
  assign any_valid = a_req_valid | b_req_valid;
  assign winner    = (a_req_valid & b_req_valid) ? ~last_grant_q : b_req_valid;
  assign win_rmode = (winner == ID_B) ? b_rmode : a_rmode;
  assign eligible  = (inflight_q == 3'd0) | (win_rmode == cur_rmode_q) |
                     ((inflight_q == 3'd1) & retire);
  assign issue     = reset & any_valid & eligible;

  assign a_req_ready = issue & (winner == ID_A);
  assign b_req_ready = issue & (winner == ID_B);
  assign mul_val_rm  = issue ? ((winner == ID_B) ? b_val_rm : a_val_rm) : 64'd0;
  assign mul_val_rn  = issue ? ((winner == ID_B) ? b_val_rn : a_val_rn) : 64'd0;
  assign mul_rmode   = issue ? win_rmode : cur_rmode_q;

  // Retire side: the multiplier datapath is unreset, so only the tag valid qualifies results
  assign res_a_valid = retire & (tag_id_q[LAT-1] == ID_A);
  assign res_b_valid = retire & (tag_id_q[LAT-1] == ID_B);
  assign res_value   = reset ? mul_val_ro : 64'd0;
  assign res_inexact = reset & mul_ex_ok[0];
  assign busy        = (inflight_q != 3'd0);
  assign inflight    = inflight_q;
  assign unused_ex   = mul_ex_ok[1];

  always_comb begin
    tag_v_d      = {tag_v_q[LAT-2:0], issue};
    tag_id_d     = {tag_id_q[LAT-2:0], winner};
    last_grant_d = last_grant_q;
    cur_rmode_d  = cur_rmode_q;
    if (issue) begin
      last_grant_d = winner;
      cur_rmode_d  = win_rmode;
    end
    inflight_d = inflight_q + {2'b00, issue} - {2'b00, retire};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      last_grant_q <= ID_B;
      cur_rmode_q  <= '0;
      inflight_q   <= 3'd0;
    end else begin
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      last_grant_q <= last_grant_d;
      cur_rmode_q  <= cur_rmode_d;
      inflight_q   <= inflight_d;
    end
  end
endmodule

// File: tb/tb_fpu_mul_sched.sv
// Bench for fpu_mul_sched: a multiplier stand-in, a queue-based scheduler model checked every cycle,
// and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_fpu_mul_sched;
  localparam int LAT = 4;
  localparam int RMW = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           a_req_valid = 1'b0, b_req_valid = 1'b0;
  logic           a_req_ready, b_req_ready;
  logic [63:0]    a_val_rm = '0, a_val_rn = '0, b_val_rm = '0, b_val_rn = '0;
  logic [RMW-1:0] a_rmode = '0, b_rmode = '0;
  logic [63:0]    mul_val_rm, mul_val_rn, mul_val_ro, res_value;
  logic [RMW-1:0] mul_rmode;
  logic [1:0]     mul_ex_ok;
  logic           res_a_valid, res_b_valid, res_inexact, busy;
  logic [2:0]     inflight;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fpu_mul_sched #(.LAT(LAT), .RMW(RMW)) dut (
    .clock(clock), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_val_rm(a_val_rm), .a_val_rn(a_val_rn), .a_rmode(a_rmode),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_val_rm(b_val_rm), .b_val_rn(b_val_rn), .b_rmode(b_rmode),
    .mul_val_rm(mul_val_rm), .mul_val_rn(mul_val_rn), .mul_rmode(mul_rmode),
    .mul_val_ro(mul_val_ro), .mul_ex_ok(mul_ex_ok),
    .res_a_valid(res_a_valid), .res_b_valid(res_b_valid),
    .res_value(res_value), .res_inexact(res_inexact),
    .busy(busy), .inflight(inflight)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: real product, inexact when low operand bits are set, mode 4 jams bit 0.
  function automatic logic sim_inx(input logic [63:0] rm, input logic [63:0] rn);
    return (rm[1:0] != 2'b00) || (rn[1:0] != 2'b00);
  endfunction

  function automatic logic [63:0] sim_mul(input logic [63:0] rm, input logic [63:0] rn,
                                          input logic [RMW-1:0] rmode);
    logic [63:0] p;
    p = $realtobits($bitstoreal(rm) * $bitstoreal(rn));
    if (rmode == 8'd4 && sim_inx(rm, rn)) p[0] = 1'b1;
    return p;
  endfunction

  typedef struct packed {
    logic [63:0]    rm;
    logic [63:0]    rn;
    logic [RMW-1:0] rmode;
  } mop_t;

  mop_t ms [LAT];
  logic ms_bad = 1'b0;

  // Rounding mode is sampled again at the last stage; a change in flight corrupts the result.
  always @(posedge clock) begin
    ms[0] <= '{rm: mul_val_rm, rn: mul_val_rn, rmode: mul_rmode};
    for (int i = 1; i < LAT; i++) ms[i] <= ms[i-1];
    ms_bad <= (ms[LAT-2].rmode != mul_rmode);
  end

  assign mul_val_ro = sim_mul(ms[LAT-1].rm, ms[LAT-1].rn, ms[LAT-1].rmode) ^
                      (ms_bad ? 64'h0000_0000_0BAD_0000 : 64'h0);
  assign mul_ex_ok  = {ms_bad, sim_inx(ms[LAT-1].rm, ms[LAT-1].rn)};

  // Reference model: queue of in-flight ops stamped with their issue cycle.
  typedef struct {
    logic           id;
    logic [63:0]    rm;
    logic [63:0]    rn;
    logic [RMW-1:0] rmode;
    int             cyc;
  } op_t;

  op_t            q[$];
  logic           m_last = 1'b1;
  logic [RMW-1:0] m_cur = '0;
  int             cyc = 0;

  always @(negedge clock) begin
    logic           retiring, win, elig, iss;
    logic [RMW-1:0] wrm;
    op_t            o;
    if (!reset) begin
      chk("reset_ctrl", {a_req_ready, b_req_ready, res_a_valid, res_b_valid, res_inexact,
                         busy, inflight, mul_rmode}, 64'd0);
      chk("reset_data", mul_val_rm | mul_val_rn | res_value, 64'd0);
      q.delete();
      m_last = 1'b1;
      m_cur  = '0;
    end else begin
      retiring = (q.size() != 0) && (q[0].cyc + LAT == cyc);
      win  = (a_req_valid && b_req_valid) ? ~m_last : b_req_valid;
      wrm  = win ? b_rmode : a_rmode;
      elig = (q.size() == 0) || (wrm == m_cur) || (q.size() == 1 && retiring);
      iss  = (a_req_valid || b_req_valid) && elig;
      chk("a_ready", a_req_ready, iss && !win);
      chk("b_ready", b_req_ready, iss && win);
      chk("mul_rmode", mul_rmode, iss ? wrm : m_cur);
      chk("mul_rm", mul_val_rm, iss ? (win ? b_val_rm : a_val_rm) : 64'd0);
      chk("mul_rn", mul_val_rn, iss ? (win ? b_val_rn : a_val_rn) : 64'd0);
      chk("res_a_valid", res_a_valid, retiring && q[0].id == 1'b0);
      chk("res_b_valid", res_b_valid, retiring && q[0].id == 1'b1);
      if (retiring) begin
        chk("res_value", res_value, sim_mul(q[0].rm, q[0].rn, q[0].rmode));
        chk("res_inexact", res_inexact, sim_inx(q[0].rm, q[0].rn));
      end
      chk("inflight", inflight, q.size());
      chk("busy", busy, q.size() != 0);
      if (retiring) void'(q.pop_front());
      if (iss) begin
        o.id    = win;
        o.rm    = win ? b_val_rm : a_val_rm;
        o.rn    = win ? b_val_rn : a_val_rn;
        o.rmode = wrm;
        o.cyc   = cyc;
        q.push_back(o);
        m_last = win;
        m_cur  = wrm;
      end
    end
    cyc++;
  end

  // Stimulus helpers
  int ga, gb, bub, max_inf;

  function automatic logic [63:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[62:52] = 11'h3F0 + 11'($urandom_range(0, 31));
    return r;
  endfunction

  task automatic new_a(input int p, input int mm);
    a_req_valid = ($urandom_range(0, 99) < p);
    a_val_rm = rnd_op();
    a_val_rn = rnd_op();
    a_rmode  = 8'($urandom_range(0, mm));
  endtask

  task automatic new_b(input int p, input int mm);
    b_req_valid = ($urandom_range(0, 99) < p);
    b_val_rm = rnd_op();
    b_val_rn = rnd_op();
    b_rmode  = 8'($urandom_range(0, mm));
  endtask

  task automatic idle(input int n);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, input int pa, input int pb, input int mm);
    logic acc_a, acc_b;
    for (int c = 0; c < n; c++) begin
      @(negedge clock); #1;
      acc_a = a_req_valid && a_req_ready;
      acc_b = b_req_valid && b_req_ready;
      if (acc_a) ga++;
      if (acc_b) gb++;
      if ((a_req_valid || b_req_valid) && !(acc_a || acc_b)) bub++;
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
      @(posedge clock); #1;
      if (!a_req_valid || acc_a) new_a(pa, mm);
      if (!b_req_valid || acc_b) new_b(pb, mm);
    end
  endtask

  initial begin
    int w, nres, a_extra;
    logic bgot;

    // Reset state
    #2;
    chk("rst_inflight", inflight, 3'd0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Single op: 1.5 * 2.0 from A
    a_req_valid = 1'b1; a_val_rm = 64'h3FF8000000000000; a_val_rn = 64'h4000000000000000;
    a_rmode = 8'd0;
    @(negedge clock); #1;
    chk("single_ready", a_req_ready, 1'b1);
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    chk("single_inflight1", inflight, 3'd1);
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("single_res_valid", res_a_valid, 1'b1);
    chk("single_res_value", res_value, 64'h4008000000000000);
    chk("single_res_inexact", res_inexact, 1'b0);
    @(posedge clock); #1;
    chk("single_inflight0", inflight, 3'd0);

    // Inexact op with rmode 4
    a_req_valid = 1'b1; a_val_rm = 64'h3FF0000000000001; a_val_rn = 64'h3FF0000000000003;
    a_rmode = 8'd4;
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("inx_valid", res_a_valid, 1'b1);
    chk("inx_flag", res_inexact, 1'b1);
    chk("inx_low_bits", res_value[1:0], 2'b01);
    idle(4);

    // Contention: both valid, same mode, 8 cycles
    ga = 0; gb = 0; bub = 0; max_inf = 0;
    new_a(100, 0); new_b(100, 0);
    run(8, 100, 100, 0);
    chk("cont_grants_a", ga, 4);
    chk("cont_grants_b", gb, 4);
    chk("cont_bubbles", bub, 0);
    chk("cont_max_inflight", max_inf, 4);
    idle(6);

    // Mode conflict: A mode 0 in flight, B mode 1 must wait for the retire cycle
    new_a(100, 0); a_rmode = 8'd0;
    @(negedge clock); #1;
    chk("conf_a_ready", a_req_ready, 1'b1);
    @(posedge clock); #1;
    a_req_valid = 1'b0;
    new_b(100, 0); b_rmode = 8'd1;
    w = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); #1;
      if (b_req_ready) break;
      chk("conf_hold_rmode", mul_rmode, 8'd0);
      w++;
    end
    chk("conf_wait_cycles", w, 3);
    @(posedge clock); #1;
    idle(6);

    // Fairness: A streams mode 0, B wants mode 2
    new_a(100, 0); a_rmode = 8'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock); #1;
      @(posedge clock); #1;
      new_a(100, 0); a_rmode = 8'd0;
    end
    new_b(100, 0); b_rmode = 8'd2;
    a_extra = 0; bgot = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); #1;
      if (b_req_ready) begin bgot = 1'b1; break; end
      if (a_req_ready) a_extra++;
      @(posedge clock); #1;
      if (a_req_ready) begin new_a(100, 0); a_rmode = 8'd0; end
    end
    chk("fair_b_granted", bgot, 1'b1);
    chk("fair_a_extra_le1", a_extra <= 1, 1'b1);
    @(posedge clock); #1;
    idle(6);

    // Reset mid-flight
    new_a(100, 0); new_b(100, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      @(posedge clock); #1;
      new_a(100, 0); new_b(100, 0);
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    nres = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock); #1;
      if (res_a_valid || res_b_valid) nres++;
    end
    chk("rst_mid_no_results", nres, 0);
    chk("rst_mid_inflight", inflight, 3'd0);
    @(posedge clock); #1;
    new_a(100, 0); new_b(100, 0);
    @(negedge clock); #1;
    chk("rst_first_grant_a", a_req_ready, 1'b1);
    chk("rst_first_grant_b", b_req_ready, 1'b0);
    @(posedge clock); #1;
    idle(6);

    // Randomized traffic with mixed rounding modes
    ga = 0; gb = 0; bub = 0; max_inf = 0;
    new_a(70, 2); new_b(60, 2);
    run(400, 70, 60, 2);
    chk("rand_both_served", (ga > 0) && (gb > 0), 1'b1);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
